// File: rtl/leaf_prim_scheduler_pkg.sv
// Shared types for the leaf primitive scheduler: default widths, leaf/range records
// and the iterator state encoding.
package leaf_prim_scheduler_pkg;

  localparam int BVH_PRIMITIVE_INDEX_WIDTH  = 16;
  localparam int BVH_PRIMITIVE_AMOUNT_WIDTH = 8;

  typedef struct packed {
    logic [BVH_PRIMITIVE_INDEX_WIDTH-1:0]  start_prim;
    logic [BVH_PRIMITIVE_AMOUNT_WIDTH-1:0] num_prim;
  } BVH_Leaf;

  typedef struct packed {
    logic [BVH_PRIMITIVE_INDEX_WIDTH-1:0]  start;
    logic [BVH_PRIMITIVE_AMOUNT_WIDTH-1:0] num;
  } PrimRange;

  typedef enum logic [1:0] {
    S_Idle = 2'd0,
    S_Emit = 2'd1,
    S_Done = 2'd2
  } LeafSchedState;

endpackage

// File: rtl/leaf_prim_scheduler_fifo.sv
// Range FIFO with two ordered write lanes and one read port. Writes beyond the free
// space are dropped and flagged; flush empties the queue and discards same-cycle writes.
module leaf_prim_scheduler_fifo
  import leaf_prim_scheduler_pkg::*;
#(
  parameter type entry_t = PrimRange,
  parameter int  DEPTH   = 8,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int LVL_W   = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [1:0]       push_cnt,
  input  entry_t           push_data [2],
  input  logic             pop,
  output entry_t           head,
  output logic [LVL_W-1:0] occupancy_next,
  output logic             empty,
  output logic             dropped
);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] occupancy;
  logic [LVL_W-1:0] free_slots;
  logic [1:0]       accepted;

  always_comb begin
    free_slots = LVL_W'(DEPTH) - occupancy;
    accepted   = push_cnt;
    // Lane 0 sits in push_data[0], so truncating the count keeps it for the last slot.
    if (LVL_W'(push_cnt) > free_slots) accepted = free_slots[1:0];
    dropped        = (accepted != push_cnt);
    occupancy_next = flush ? '0 : occupancy + LVL_W'(accepted) - LVL_W'(pop);
  end

  assign empty = (occupancy == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      wr_ptr    <= wr_ptr + PTR_W'(accepted);
      rd_ptr    <= rd_ptr + PTR_W'(pop);
      occupancy <= occupancy_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!flush) begin
      if (accepted != 2'd0) mem[wr_ptr] <= push_data[0];
      if (accepted == 2'd2) mem[wr_ptr + PTR_W'(1)] <= push_data[1];
    end
  end

endmodule

// File: rtl/leaf_prim_scheduler.sv
// Buffers leaf ranges from BVH traversal and walks each one, issuing one primitive
// index per accepted handshake with back-to-back range chaining.
module leaf_prim_scheduler
  import leaf_prim_scheduler_pkg::*;
#(
  parameter int PRIM_INDEX_WIDTH  = BVH_PRIMITIVE_INDEX_WIDTH,
  parameter int PRIM_AMOUNT_WIDTH = BVH_PRIMITIVE_AMOUNT_WIDTH,
  parameter int RANGE_FIFO_DEPTH  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         restart_strobe,
  input  logic [PRIM_INDEX_WIDTH-1:0]  in_start_prim [2],
  input  logic [PRIM_AMOUNT_WIDTH-1:0] in_num_prim [2],
  input  logic                         bvh_finished,
  output logic                         ranges_full,
  output logic [PRIM_INDEX_WIDTH-1:0]  prim_index,
  output logic                         prim_valid,
  input  logic                         prim_ready,
  output logic                         all_done,
  output logic                         overflow
);

  localparam int LVL_W = $clog2(RANGE_FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [PRIM_INDEX_WIDTH-1:0]  start;
    logic [PRIM_AMOUNT_WIDTH-1:0] num;
  } range_t;

  LeafSchedState                state, state_next;
  logic [PRIM_INDEX_WIDTH-1:0]  cur_start, offset;
  logic [PRIM_AMOUNT_WIDTH-1:0] remaining;
  logic [1:0]                   lane_push;
  range_t                       lane_range [2];
  range_t                       push_data [2];
  range_t                       fifo_head, load_range;
  logic [1:0]                   push_cnt;
  logic                         handshake, last_hs, fifo_pop, bypass, load;
  logic                         fifo_empty, fifo_dropped;
  logic [LVL_W-1:0]             fifo_occupancy_next;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      lane_push[k]        = (in_num_prim[k] != '0);
      lane_range[k].start = in_start_prim[k];
      lane_range[k].num   = in_num_prim[k];
    end
  end

  always_comb begin
    handshake  = (state == S_Emit) && prim_ready;
    last_hs    = handshake && (remaining == PRIM_AMOUNT_WIDTH'(1));
    fifo_pop   = ((state == S_Idle) || last_hs) && !fifo_empty;
    // An idle block with nothing buffered takes the first incoming range directly.
    bypass     = (state == S_Idle) && fifo_empty && (|lane_push);
    load       = fifo_pop || bypass;
    load_range = fifo_pop ? fifo_head : (lane_push[0] ? lane_range[0] : lane_range[1]);
    push_data[0] = lane_push[0] ? lane_range[0] : lane_range[1];
    push_data[1] = lane_range[1];
    push_cnt     = {1'b0, lane_push[0]} + {1'b0, lane_push[1]};
    if (bypass) begin
      push_data[0] = lane_range[1];
      push_cnt     = {1'b0, &lane_push};
    end
  end

  leaf_prim_scheduler_fifo #(
    .entry_t (range_t),
    .DEPTH   (RANGE_FIFO_DEPTH)
  ) u_fifo (
    .clk            (clk),
    .reset          (reset),
    .flush          (restart_strobe),
    .push_cnt       (push_cnt),
    .push_data      (push_data),
    .pop            (fifo_pop),
    .head           (fifo_head),
    .occupancy_next (fifo_occupancy_next),
    .empty          (fifo_empty),
    .dropped        (fifo_dropped)
  );

  always_comb begin
    state_next = state;
    case (state)
      S_Idle: begin
        if (load)              state_next = S_Emit;
        else if (bvh_finished) state_next = S_Done;
      end
      S_Emit:  if (last_hs && !fifo_pop) state_next = S_Idle;
      S_Done:  if (|lane_push) state_next = S_Idle;
      default: state_next = S_Idle;
    endcase
    if (restart_strobe) state_next = S_Idle;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_Idle;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_start   <= '0;
      offset      <= '0;
      remaining   <= '0;
      overflow    <= 1'b0;
      ranges_full <= 1'b0;
    end else if (restart_strobe) begin
      cur_start   <= '0;
      offset      <= '0;
      remaining   <= '0;
      overflow    <= 1'b0;
      ranges_full <= 1'b0;
    end else begin
      if (load) begin
        cur_start <= load_range.start;
        offset    <= '0;
        remaining <= load_range.num;
      end else if (handshake) begin
        offset    <= offset + PRIM_INDEX_WIDTH'(1);
        remaining <= remaining - PRIM_AMOUNT_WIDTH'(1);
      end
      overflow    <= overflow | fifo_dropped;
      ranges_full <= (fifo_occupancy_next >= LVL_W'(RANGE_FIFO_DEPTH - 1));
    end
  end

  assign prim_valid = (state == S_Emit);
  assign prim_index = prim_valid ? cur_start + offset : '1;
  assign all_done   = (state == S_Done);

endmodule

// File: tb/tb_leaf_prim_scheduler.sv
// Directed bench for leaf_prim_scheduler: a queue-based reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_leaf_prim_scheduler;

  localparam int IW    = 16;
  localparam int AW    = 8;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          restart_strobe;
  logic [IW-1:0] in_start [2];
  logic [AW-1:0] in_num [2];
  logic          bvh_finished;
  logic          ranges_full;
  logic [IW-1:0] prim_index;
  logic          prim_valid;
  logic          prim_ready;
  logic          all_done;
  logic          overflow;

  int n_checks = 0;
  int n_fail   = 0;

  leaf_prim_scheduler #(
    .PRIM_INDEX_WIDTH  (IW),
    .PRIM_AMOUNT_WIDTH (AW),
    .RANGE_FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .restart_strobe (restart_strobe),
    .in_start_prim  (in_start),
    .in_num_prim    (in_num),
    .bvh_finished   (bvh_finished),
    .ranges_full    (ranges_full),
    .prim_index     (prim_index),
    .prim_valid     (prim_valid),
    .prim_ready     (prim_ready),
    .all_done       (all_done),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a plain queue of pending ranges plus the range being walked.
  typedef struct {
    logic [IW-1:0] s;
    logic [AW-1:0] n;
  } rng_t;

  rng_t          m_q[$];
  bit            m_active = 0;
  bit            m_done   = 0;
  bit            m_ovf    = 0;
  bit            m_full   = 0;
  logic [IW-1:0] m_idx    = '0;
  int            m_rem    = 0;

  task automatic model_clear();
    m_q.delete();
    m_active = 0;
    m_done   = 0;
    m_ovf    = 0;
    m_full   = 0;
    m_idx    = '0;
    m_rem    = 0;
  endtask

  task automatic model_step();
    rng_t inc[$];
    rng_t r;
    bit   was_active, was_idle, got;
    int   pre, acc;
    for (int k = 0; k < 2; k++)
      if (in_num[k] != 0) begin
        r.s = in_start[k];
        r.n = in_num[k];
        inc.push_back(r);
      end
    was_active = m_active;
    was_idle   = !m_active && !m_done;
    pre        = m_q.size();
    acc        = 0;
    got        = 0;
    if (m_active && prim_ready) begin
      m_idx = m_idx + 1'b1;
      m_rem--;
      if (m_rem == 0) m_active = 0;
    end
    if (was_idle || (was_active && !m_active)) begin
      if (m_q.size() > 0) begin
        r = m_q.pop_front();
        got = 1;
      end else if (was_idle && inc.size() > 0) begin
        r = inc.pop_front();
        got = 1;
      end
      if (got) begin
        m_active = 1;
        m_idx    = r.s;
        m_rem    = int'(r.n);
      end
    end
    foreach (inc[i]) begin
      if (pre + acc < DEPTH) begin
        m_q.push_back(inc[i]);
        acc++;
      end else begin
        m_ovf = 1;
      end
    end
    if (m_done && (in_num[0] != 0 || in_num[1] != 0)) m_done = 0;
    else if (was_idle && !got && bvh_finished) m_done = 1;
    m_full = (m_q.size() >= DEPTH - 1);
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset)               model_clear();
    else if (restart_strobe) model_clear();
    else                     model_step();
  end

  always @(negedge clk) begin
    chk("cmp_valid", prim_valid, m_active);
    chk("cmp_index", prim_index, m_active ? m_idx : {IW{1'b1}});
    chk("cmp_all_done", all_done, m_done);
    chk("cmp_overflow", overflow, m_ovf);
    chk("cmp_ranges_full", ranges_full, m_full);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic lane(input int k, input logic [IW-1:0] s, input logic [AW-1:0] n);
    in_start[k] = s;
    in_num[k]   = n;
  endtask

  task automatic no_lanes();
    lane(0, '0, '0);
    lane(1, '0, '0);
  endtask

  initial begin
    reset          = 1'b1;
    restart_strobe = 1'b0;
    bvh_finished   = 1'b0;
    prim_ready     = 1'b0;
    no_lanes();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_valid_index", {prim_valid, prim_index}, {1'b0, 16'hFFFF});
    chk("reset_flags", {ranges_full, all_done, overflow}, 3'b000);

    // Single range, first index one cycle after the push.
    prim_ready = 1'b1;
    lane(0, 16'd10, 8'd3);
    cyc(); no_lanes();
    chk("single_0", {prim_valid, prim_index}, {1'b1, 16'd10});
    cyc(); chk("single_1", {prim_valid, prim_index}, {1'b1, 16'd11});
    cyc(); chk("single_2", {prim_valid, prim_index}, {1'b1, 16'd12});
    cyc(); chk("single_end", {prim_valid, prim_index}, {1'b0, 16'hFFFF});

    // Dual push, lane order, no bubble, then all_done.
    lane(0, 16'd4, 8'd2);
    lane(1, 16'd20, 8'd1);
    cyc(); no_lanes();
    chk("dual_0", {prim_valid, prim_index}, {1'b1, 16'd4});
    cyc(); chk("dual_1", {prim_valid, prim_index}, {1'b1, 16'd5});
    cyc(); chk("dual_2", {prim_valid, prim_index}, {1'b1, 16'd20});
    bvh_finished = 1'b1;
    cyc(); chk("dual_idle", {prim_valid, all_done}, 2'b00);
    cyc(); chk("dual_done", all_done, 1'b1);
    bvh_finished = 1'b0;
    cyc(); chk("done_holds", all_done, 1'b1);
    lane(0, 16'd100, 8'd1);
    cyc(); no_lanes();
    chk("late_push", {prim_valid, all_done}, 2'b00);
    cyc(); chk("late_emit", {prim_valid, prim_index}, {1'b1, 16'd100});
    cyc(); chk("late_end", prim_valid, 1'b0);

    // Backpressure holds index and valid.
    prim_ready = 1'b0;
    lane(0, 16'd7, 8'd2);
    cyc(); no_lanes();
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold", {prim_valid, prim_index}, {1'b1, 16'd7});
      cyc();
    end
    chk("bp_hold_last", {prim_valid, prim_index}, {1'b1, 16'd7});
    prim_ready = 1'b1;
    cyc(); chk("bp_next", {prim_valid, prim_index}, {1'b1, 16'd8});
    cyc(); chk("bp_end", prim_valid, 1'b0);

    // Fill the FIFO behind a stalled range; the ninth buffered push is dropped.
    prim_ready = 1'b0;
    lane(0, 16'd200, 8'd1);
    cyc(); chk("full_head", {prim_valid, prim_index}, {1'b1, 16'd200});
    for (int i = 0; i < 9; i++) begin
      lane(0, 16'(50 + i), 8'd1);
      cyc();
      if (i == 5) chk("full_at6", ranges_full, 1'b0);
      if (i == 6) chk("full_at7", ranges_full, 1'b1);
      if (i == 7) chk("ovf_at8", overflow, 1'b0);
      if (i == 8) chk("ovf_dropped", overflow, 1'b1);
    end
    no_lanes();
    prim_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      cyc();
      chk("drain", {prim_valid, prim_index}, {1'b1, 16'(50 + j)});
    end
    cyc(); chk("drain_end", {prim_valid, overflow, ranges_full}, 3'b010);

    // Index wrap-around.
    lane(0, 16'hFFFE, 8'd3);
    cyc(); no_lanes();
    chk("wrap_0", {prim_valid, prim_index}, {1'b1, 16'hFFFE});
    cyc(); chk("wrap_1", {prim_valid, prim_index}, {1'b1, 16'hFFFF});
    cyc(); chk("wrap_2", {prim_valid, prim_index}, {1'b1, 16'h0000});
    cyc(); chk("wrap_end", prim_valid, 1'b0);

    // Restart mid-range with a same-cycle push that must be discarded.
    lane(0, 16'h0500, 8'd5);
    cyc(); no_lanes();
    chk("rs_0", {prim_valid, prim_index}, {1'b1, 16'h0500});
    cyc(); chk("rs_1", {prim_valid, prim_index}, {1'b1, 16'h0501});
    restart_strobe = 1'b1;
    lane(1, 16'h0700, 8'd2);
    cyc(); restart_strobe = 1'b0; no_lanes();
    chk("rs_flushed", {prim_valid, prim_index}, {1'b0, 16'hFFFF});
    chk("rs_flags", {overflow, ranges_full, all_done}, 3'b000);
    cyc(); chk("rs_empty", prim_valid, 1'b0);

    // Asynchronous reset in the middle of a cycle during emission.
    lane(0, 16'h0040, 8'd4);
    cyc(); no_lanes();
    chk("ar_0", {prim_valid, prim_index}, {1'b1, 16'h0040});
    cyc(); chk("ar_1", {prim_valid, prim_index}, {1'b1, 16'h0041});
    #2 reset = 1'b1;
    #1 chk("ar_async", {prim_valid, prim_index}, {1'b0, 16'hFFFF});
    chk("ar_flags", {ranges_full, all_done, overflow}, 3'b000);
    @(posedge clk);
    #1 reset = 1'b0;
    cyc(); chk("ar_abandoned", prim_valid, 1'b0);
    cyc(); chk("ar_quiet", prim_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
